// File: rtl/rf_wb_arbiter.sv
// Two-port register-file writeback arbiter with a one-bit round-robin pointer,
// one-cycle registered write path and per-register pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NREG      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb0_valid,
  input  logic [1:0]           wb0_addr,
  input  logic [WORD_SIZE-1:0] wb0_data,
  output logic                 wb0_ready,
  input  logic                 wb1_valid,
  input  logic [1:0]           wb1_addr,
  input  logic [WORD_SIZE-1:0] wb1_data,
  output logic                 wb1_ready,
  input  logic                 rsv_valid,
  input  logic [1:0]           rsv_addr,
  output logic                 rsv_ready,
  output logic                 rf_write,
  output logic [1:0]           rf_addr_w,
  output logic [WORD_SIZE-1:0] rf_data_w,
  output logic [NREG-1:0]      busy,
  output logic                 err_unreserved
);

  logic            last_grant;
  logic            xfer0;
  logic            xfer1;
  logic            xfer_any;
  logic [NREG-1:0] busy_nxt;

  // Grant depends only on the valids and the pointer; on a tie the port
  // that did not win last time is served.
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    if (wb0_valid && wb1_valid) begin
      wb0_ready = last_grant;
      wb1_ready = ~last_grant;
    end else begin
      wb0_ready = wb0_valid;
      wb1_ready = wb1_valid;
    end
  end

  assign xfer0     = wb0_valid & wb0_ready;
  assign xfer1     = wb1_valid & wb1_ready;
  assign xfer_any  = xfer0 | xfer1;
  assign rsv_ready = ~busy[rsv_addr];

  // Clear on commit first, then set on reservation; a same-address collision
  // can only occur for an unreserved write, where the new reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_write) begin
      busy_nxt[rf_addr_w] = 1'b0;
    end
    if (rsv_valid && rsv_ready) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant     <= 1'b1;
      rf_write       <= 1'b0;
      rf_addr_w      <= 2'd0;
      rf_data_w      <= '0;
      busy           <= '0;
      err_unreserved <= 1'b0;
    end else begin
      rf_write <= xfer_any;
      if (xfer_any) begin
        last_grant <= xfer1;
        rf_addr_w  <= xfer1 ? wb1_addr : wb0_addr;
        rf_data_w  <= xfer1 ? wb1_data : wb0_data;
      end
      busy <= busy_nxt;
      if (rf_write && !busy[rf_addr_w]) begin
        err_unreserved <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected RF writes into a
// queue, a negedge monitor pops and compares them as rf_write pulses appear.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb0_valid = 1'b0;
  logic [1:0]  wb0_addr = 2'd0;
  logic [15:0] wb0_data = 16'd0;
  logic        wb0_ready;
  logic        wb1_valid = 1'b0;
  logic [1:0]  wb1_addr = 2'd0;
  logic [15:0] wb1_data = 16'd0;
  logic        wb1_ready;
  logic        rsv_valid = 1'b0;
  logic [1:0]  rsv_addr = 2'd0;
  logic        rsv_ready;
  logic        rf_write;
  logic [1:0]  rf_addr_w;
  logic [15:0] rf_data_w;
  logic [3:0]  busy;
  logic        err_unreserved;

  int checks = 0;
  int errors = 0;
  wr_t sb[$];

  rf_wb_arbiter #(.WORD_SIZE(16), .NREG(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rf_write(rf_write), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
    .busy(busy), .err_unreserved(err_unreserved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle at posedge+1, check readies at negedge, record the
  // expected winner's write, and return just after the next posedge.
  task automatic step(input logic v0, input logic [1:0] a0, input logic [15:0] d0,
                      input logic v1, input logic [1:0] a1, input logic [15:0] d1,
                      input logic rv, input logic [1:0] ra,
                      input logic e0, input logic e1, input logic er);
    wr_t w;
    wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
    wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    rsv_valid = rv; rsv_addr = ra;
    @(negedge clk);
    chk("wb0_ready", 32'(wb0_ready), 32'(e0));
    chk("wb1_ready", 32'(wb1_ready), 32'(e1));
    chk("rsv_ready", 32'(rsv_ready), 32'(er));
    if (e0 && v0) begin
      w.addr = a0; w.data = d0; sb.push_back(w);
    end else if (e1 && v1) begin
      w.addr = a1; w.data = d1; sb.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rv, input logic [1:0] ra, input logic er);
    step(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, rv, ra, 1'b0, 1'b0, er);
  endtask

  // Scoreboard monitor: every RF write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n) begin
      checks++;
      if (wb0_ready && wb1_ready) begin
        errors++;
        $display("FAIL both_ready: got wb0_ready=1 wb1_ready=1, expected at most one");
      end
      if (rf_write) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", rf_addr_w, rf_data_w);
        end else begin
          e = sb.pop_front();
          chk("sb_rf_addr_w", 32'(rf_addr_w), 32'(e.addr));
          chk("sb_rf_data_w", 32'(rf_data_w), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #13;
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_addr_w", 32'(rf_addr_w), 32'd0);
    chk("rst_rf_data_w", 32'(rf_data_w), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_unreserved), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reserve r1, r3; both ports valid: first tie after reset goes to wb0.
    idle(1'b1, 2'd1, 1'b1);
    idle(1'b1, 2'd3, 1'b1);
    chk("busy_r1_r3", 32'(busy), 32'h0000000a);
    step(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd3, 16'h5555, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("busy_hold_c", 32'(busy), 32'h0000000a);
    chk("rf_write_c", 32'(rf_write), 32'd1);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 16'h5555, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("rf_write_d", 32'(rf_write), 32'd1);
    chk("busy_r1_clr", 32'(busy), 32'h00000008);
    idle(1'b0, 2'd0, 1'b1);
    chk("busy_all_clr", 32'(busy), 32'd0);
    chk("err_none", 32'(err_unreserved), 32'd0);

    // Reserve r2, wb0 writes 0x1234; clear of r2 and reservation of r1 coincide.
    idle(1'b1, 2'd2, 1'b1);
    step(1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("busy_r2_pending", 32'(busy), 32'h00000004);
    chk("rf_write_g", 32'(rf_write), 32'd1);
    idle(1'b1, 2'd1, 1'b1);
    chk("busy_r2clr_r1set", 32'(busy), 32'h00000002);
    chk("rf_write_idle", 32'(rf_write), 32'd0);
    chk("rf_addr_hold", 32'(rf_addr_w), 32'd2);
    chk("rf_data_hold", 32'(rf_data_w), 32'h1234);

    // Unreserved write to r3: error rises at the commit edge and sticks.
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 16'hBEEF, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("err_before_commit", 32'(err_unreserved), 32'd0);
    chk("rf_write_unres", 32'(rf_write), 32'd1);
    idle(1'b0, 2'd0, 1'b1);
    chk("err_after_commit", 32'(err_unreserved), 32'd1);

    // Four-cycle tie on the same register: wb0, wb1, wb0, wb1.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd2, 16'(16'h1000 + i), 1'b1, 2'd2, 16'(16'h2000 + i),
           1'b0, 2'd0, (i % 2 == 0), (i % 2 == 1), 1'b1);
      chk("alt_rf_write", 32'(rf_write), 32'd1);
    end

    // Reservation of a busy register is refused until its write commits.
    idle(1'b1, 2'd0, 1'b1);
    chk("rf_data_last_alt", 32'(rf_data_w), 32'h2003);
    step(1'b1, 2'd0, 16'h0F0F, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2'd0, 1'b0);
    idle(1'b1, 2'd0, 1'b1);
    chk("busy_r0_rereserved", 32'(busy), 32'h00000003);
    chk("err_sticky", 32'(err_unreserved), 32'd1);

    // Reset right after a transfer drops the pending write.
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 16'hCAFE, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("rf_write_pre_rst", 32'(rf_write), 32'd1);
    wb1_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_rf_write", 32'(rf_write), 32'd0);
    chk("arst_rf_addr_w", 32'(rf_addr_w), 32'd0);
    chk("arst_rf_data_w", 32'(rf_data_w), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_unreserved), 32'd0);
    chk("arst_wb0_ready", 32'(wb0_ready), 32'd0);
    chk("arst_wb1_ready", 32'(wb1_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b0, 2'd0, 1'b1);
    chk("post_rst_no_write", 32'(rf_write), 32'd0);
    step(1'b1, 2'd0, 16'h1111, 1'b1, 2'd1, 16'h2222, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b0, 2'd0, 1'b1);
    idle(1'b0, 2'd0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
- WORD_SIZE, 16, data width.
- NREG, 4, number of registers (fixed by 2-bit address).
REQ-002 Clock and reset SHALL be clk and reset_n: reset reset_n, asynchronous, active-low; clock clk.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- wb0_valid  in  1  ALU writeback request
- wb0_addr  in  2  ALU destination register
- wb0_data  in  16  ALU result
- wb0_ready  out  1  ALU request accepted
- wb1_valid  in  1  memory-load writeback request
- wb1_addr  in  2  load destination register
- wb1_data  in  16  load data
- wb1_ready  out  1  load request accepted
- rsv_valid  in  1  issue stage reserves a destination
- rsv_addr  in  2  register to reserve
- rsv_ready  out  1  reservation accepted
- rf_write  out  1  register-file write enable
- rf_addr_w  out  2  register-file write address
- rf_data_w  out  16  register-file write data
- busy  out  4  per-register pending-write flags
- err_unreserved  out  1  sticky: write committed to non-busy register

Function
REQ-004 A writeback transfer on port N SHALL occur at a rising clk edge where wbN_valid and wbN_ready are both 1.
REQ-005 At most one of wb0_ready and wb1_ready SHALL be 1 in any cycle.
REQ-006 If exactly one wbN_valid is 1, that port's ready SHALL be 1.
REQ-007 If both valids are 1, ready SHALL go to the port not equal to last_grant (1-bit round-robin pointer).
REQ-008 wbN_ready SHALL be combinational from wb0_valid, wb1_valid and last_grant only; it SHALL NOT depend on addr or data.
REQ-009 last_grant SHALL update to the granted port on every transfer and hold otherwise.
REQ-010 A transfer at edge k SHALL produce rf_write=1 with the captured addr/data during cycle k+1; latency is exactly one cycle.
REQ-011 With no transfer, rf_write SHALL be 0 in the following cycle; rf_addr_w/rf_data_w SHALL hold their last values.
REQ-012 Back-to-back transfers SHALL sustain one RF write per cycle with no bubble.
REQ-013 A reservation SHALL occur at an edge where rsv_valid and rsv_ready are both 1; it sets busy[rsv_addr].
REQ-014 rsv_ready SHALL equal ~busy[rsv_addr], combinationally.
REQ-015 busy[a] SHALL clear at the edge ending a cycle with rf_write=1 and rf_addr_w=a (the edge the RF stores the data).
REQ-016 A clear of address a and a reservation of address b != a at the same edge SHALL both take effect.
REQ-017 If rf_write=1 while busy[rf_addr_w]=0, err_unreserved SHALL be set at that edge and stay 1 until reset; the write still proceeds.
REQ-018 Both ports targeting the same address SHALL be served in round-robin order on consecutive cycles; the RF ends with the later write.

Reset
REQ-019 On reset_n=0, asynchronously:
- busy=0, last_grant=1, err_unreserved=0
- rf_write=0, rf_addr_w=0, rf_data_w=0
REQ-020 A transfer accepted in the cycle before reset assertion SHALL be dropped; no rf_write pulse SHALL appear after reset release.
REQ-021 After reset_n rises, the first tie SHALL grant wb0.

Verification
REQ-022 Bench SHALL cover:
- rsv r2; wb0 addr2 data 0x1234 -> wb0_ready=1; next cycle rf_write=1, rf_addr_w=2, rf_data_w=0x1234; busy[2]=0 the cycle after.
- rsv r1 and r3; wb0(r1,0xAAAA) and wb1(r3,0x5555) held valid together -> grants wb0 then wb1; rf_write high two consecutive cycles; no error.
- Both valid 4 cycles -> grant sequence wb0, wb1, wb0, wb1; never both ready.
- busy[0]=1, rsv_addr=0 -> rsv_ready=0 until the cycle after the r0 write commits, then 1.
- wb1 writes r3 with busy[3]=0 -> err_unreserved rises at the commit edge, stays 1, RF write still issued.
- Assert reset_n=0 the cycle after a transfer -> rf_write=0 immediately; all outputs 0; busy=0.
